controller_port_array: RTL and testbench

- Parametrised successor to the idle-stub controller interface at $4016/$4017.
- Implements NES-style serial controller ports: one strobe latch written via $4016 bit0, plus per-port parallel-in/serial-out shift registers read one bit per CPU read.
- Sits on the CPU bus beside the APU register block. Button state comes from host-side inputs through a 2-flop synchroniser.
- Ports that are not present read as the idle value.

---
 rtl/nes_ctrl_pkg.sv | 14 +
 rtl/controller_shift_port.sv | 26 ++
 rtl/controller_port_array.sv | 75 +++++++
 tb/tb_controller_port_array.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_ctrl_pkg.sv
// Shared constants for the NES-style serial controller ports.
package nes_ctrl_pkg;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic CTRL_ADDR_P0 = 1'b0;
    localparam logic CTRL_ADDR_P1 = 1'b1;
endpackage

// File: rtl/controller_shift_port.sv
// One controller port: parallel-load / serial-out shift register, LSB first.
module controller_shift_port #(
    parameter int   BTN_BITS = 8,
    parameter logic FILL_BIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift_en,
    input  logic [BTN_BITS-1:0] par_in,
    output logic                ser_out
);
    logic [BTN_BITS-1:0] shreg;

    // Load wins over shift so a held strobe keeps presenting the live A button.
    always_ff @(posedge clk) begin
        if (!rst_n)
            shreg <= {BTN_BITS{FILL_BIT}};
        else if (load)
            shreg <= par_in;
        else if (shift_en)
            shreg <= {FILL_BIT, shreg[BTN_BITS-1:1]};
    end

    assign ser_out = shreg[0];
endmodule

// File: rtl/controller_port_array.sv
// $4016/$4017 controller ports: strobe latch, button synchroniser, per-port
// shift registers and the CPU bus read tristate.
module controller_port_array
    import nes_ctrl_pkg::*;
#(
    parameter int         NUM_PORTS = 2,
    parameter int         BTN_BITS  = 8,
    parameter logic       FILL_BIT  = 1'b1,
    parameter logic [7:0] OPEN_BUS  = 8'h40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs,
    input  logic                          rw,
    input  logic                          addr,
    inout  wire  [7:0]                    cpubus,
    input  logic [NUM_PORTS*BTN_BITS-1:0] btn,
    input  logic [NUM_PORTS-1:0]          present,
    output logic                          strobe_out
);
    logic [NUM_PORTS*BTN_BITS-1:0] btn_m, btn_s;
    logic [NUM_PORTS-1:0]          rd, rd_q, shift_en, ser;
    logic                          strobe, wr_strobe, rd_any, rd_bit;
    logic                          unused_bus_hi;

    assign wr_strobe     = !cs && !rw && (addr == CTRL_ADDR_P0);
    assign rd_any        = !cs && rw;
    assign unused_bus_hi = ^cpubus[7:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m  <= '0;
            btn_s  <= '0;
            strobe <= 1'b0;
            rd_q   <= '0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            rd_q  <= rd;
            if (wr_strobe)
                strobe <= cpubus[0];
        end
    end

    assign strobe_out = strobe;

    // Shift fires on the falling edge of each port's read decode, so a
    // multi-cycle read advances the register exactly once.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rd[p]       = rd_any && (addr == 1'(p));
        assign shift_en[p] = rd_q[p] && !rd[p];

        controller_shift_port #(
            .BTN_BITS (BTN_BITS),
            .FILL_BIT (FILL_BIT)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (strobe),
            .shift_en (shift_en[p]),
            .par_in   (btn_s[p*BTN_BITS +: BTN_BITS]),
            .ser_out  (ser[p])
        );
    end

    // Absent ports, and addr=1 on a single-port build, read back 0 in bit0.
    always_comb begin
        rd_bit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (rd[p] && present[p])
                rd_bit = ser[p];
    end

    assign cpubus = rd_any ? {OPEN_BUS[7:1], rd_bit} : 8'hzz;
endmodule

// File: tb/tb_controller_port_array.sv
// Randomised scoreboard bench for controller_port_array (2-port and 1-port builds).
module tb_controller_port_array;
    localparam int BB = 8;

    typedef struct {
        logic [7:0] m;
        logic [7:0] o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, cs, rw, addr, tb_oe;
    logic [7:0]  tb_drv;
    logic [15:0] btn;
    logic [1:0]  present;
    logic        strobe_out, strobe_out1;
    logic        rd_act = 1'b0, chk_en = 1'b0;
    wire  [7:0]  cpubus, cpubus1;

    int tests = 0, fails = 0;
    exp_t sb[$];

    // reference model: latched report plus number of completed reads per port
    logic       m_strobe = 1'b0;
    logic [7:0] m_rep [2] = '{8'hFF, 8'hFF};
    int         m_cnt [2] = '{0, 0};
    logic [1:0] m_rdp = 2'b00;
    logic [15:0] m_s1 = '0, m_s2 = '0;

    always #5 clk = ~clk;

    assign cpubus  = tb_oe ? tb_drv : 8'hzz;
    assign cpubus1 = tb_oe ? tb_drv : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (cpubus[i]);
        pullup (cpubus1[i]);
    end

    controller_port_array #(.NUM_PORTS(2), .BTN_BITS(BB), .FILL_BIT(1'b1), .OPEN_BUS(8'h40)) u_dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rw(rw), .addr(addr), .cpubus(cpubus),
        .btn(btn), .present(present), .strobe_out(strobe_out));

    controller_port_array #(.NUM_PORTS(1), .BTN_BITS(BB), .FILL_BIT(1'b1), .OPEN_BUS(8'h40)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rw(rw), .addr(addr), .cpubus(cpubus1),
        .btn(btn[7:0]), .present(present[0:0]), .strobe_out(strobe_out1));

    always @(posedge clk) begin
        if (!rst_n) begin
            m_strobe = 1'b0;
            m_rdp    = 2'b00;
            m_s1     = '0;
            m_s2     = '0;
            for (int p = 0; p < 2; p++) begin
                m_rep[p] = 8'hFF;
                m_cnt[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                logic rdn;
                rdn = !cs && rw && (int'(addr) == p);
                if (m_rdp[p] && !rdn && m_cnt[p] <= BB) m_cnt[p]++;
                if (m_strobe) begin
                    m_rep[p] = m_s2[p*BB +: BB];
                    m_cnt[p] = 0;
                end
                m_rdp[p] = rdn;
            end
            if (!cs && !rw && !addr) m_strobe = tb_drv[0];
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    function automatic logic [7:0] exp_bus(input int p);
        logic d;
        if (!present[p])      d = 1'b0;
        else if (m_cnt[p] < BB) d = m_rep[p][m_cnt[p]];
        else                  d = 1'b1;
        return {7'h20, d};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (rd_act) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got empty want entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_p2", cpubus, e.m);
                    chk("rd_p1", cpubus1, e.o);
                end
            end else if (!tb_oe) begin
                chk("hiz_p2", cpubus, 8'hFF);
                chk("hiz_p1", cpubus1, 8'hFF);
            end
            chk("strobe_out", {7'd0, strobe_out}, {7'd0, m_strobe});
            chk("strobe_out1", {7'd0, strobe_out1}, {7'd0, m_strobe});
        end
    end

    task automatic push_exp(input logic a);
        exp_t e;
        e.m = exp_bus(int'(a));
        e.o = a ? 8'h40 : exp_bus(0);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        cs = 1'b1; rw = 1'b1; tb_oe = 1'b0; rd_act = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cs = 1'b0; rw = 1'b0; addr = a; tb_oe = 1'b1; tb_drv = d; rd_act = 1'b0;
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic rd(input logic a, input int len);
        repeat (len) begin
            cs = 1'b0; rw = 1'b1; addr = a; tb_oe = 1'b0; rd_act = 1'b1;
            push_exp(a);
            @(posedge clk); #1;
        end
        cs = 1'b1; rd_act = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cs = 1'b1; rw = 1'b1; addr = 1'b0; tb_oe = 1'b0; tb_drv = 8'h00;
        btn = 16'h0000; present = 2'b11; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // pad pattern A5 read out LSB first, then fill
        btn[7:0] = 8'hA5;
        idle(3); wr(0, 8'h01); wr(0, 8'h00); idle(1);
        repeat (10) begin rd(0, 1); idle(1); end

        // held strobe tracks live A
        wr(0, 8'h01);
        repeat (3) begin btn[0] = ~btn[0]; idle(1); rd(0, 1); idle(1); end
        wr(0, 8'h00); idle(1);

        // multi-cycle read shifts once
        btn[15:8] = 8'h02;
        idle(3); wr(0, 8'h01); wr(0, 8'h00); idle(1);
        rd(1, 3); idle(1); rd(1, 1); idle(1);

        // absent port 1
        present = 2'b01; btn[15:8] = 8'hFF;
        idle(3); wr(0, 8'h01); wr(0, 8'h00); idle(1);
        rd(1, 1); idle(1); rd(0, 1); idle(1);
        present = 2'b11;

        // reset in the middle of a read after three shifts
        btn[7:0] = 8'h5A;
        idle(3); wr(0, 8'h01); wr(0, 8'h00); idle(1);
        repeat (3) begin rd(0, 1); idle(1); end
        cs = 1'b0; rw = 1'b1; addr = 1'b0; rd_act = 1'b1; push_exp(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; push_exp(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; push_exp(1'b0);
        @(posedge clk); #1;
        idle(2);
        repeat (3) begin rd(0, 1); idle(1); end

        // writes to $4017 never touch the strobe
        wr(1, 8'hFF); idle(1); rd(0, 1); idle(1);

        repeat (400) begin
            case ($urandom_range(0, 5))
                0: begin btn = 16'($urandom); idle(1); end
                1: wr(0, {7'($urandom), 1'($urandom_range(0, 1))});
                2: wr(1, 8'($urandom));
                3, 4: rd(1'($urandom_range(0, 1)), $urandom_range(1, 3));
                default: present = 2'($urandom_range(0, 3));
            endcase
            idle($urandom_range(0, 1));
        end

        idle(3);
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
